// File: rtl/branch_resolve.sv
// Branch/jump resolution stage: captures one branch, evaluates it for one cycle, then holds
// the result for fetch until the consumer accepts it.
module branch_resolve #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic            in_jal,
    input  logic            in_jalr,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic            res_redirect,
    output logic [XLEN-1:0] res_target,
    output logic [XLEN-1:0] res_link,
    output logic            res_misalign,
    output logic            res_illegal,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once raised, res_valid and all res_* stay stable until that transfer (or flush/reset).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [XLEN-1:0] r_pc, r_imm, r_rs1, r_rs2;
    logic [2:0]      r_funct3;
    logic            r_jal, r_jalr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_EVAL;
            S_EVAL:  w_next = S_HOLD;
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    assign in_ready  = (r_state == S_IDLE);
    assign res_valid = (r_state == S_HOLD);
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_imm    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_funct3 <= '0;
            r_jal    <= 1'b0;
            r_jalr   <= 1'b0;
        end else if (r_state == S_IDLE && in_valid && !flush) begin
            r_pc     <= in_pc;
            r_imm    <= in_imm;
            r_rs1    <= in_rs1;
            r_rs2    <= in_rs2;
            r_funct3 <= in_funct3;
            r_jal    <= in_jal;
            r_jalr   <= in_jalr;
        end
    end

    // funct3 decode: bit2 selects a less-than compare, bit1 unsigned, bit0 inverts the outcome.
    logic            w_lt, w_uns, w_inv, w_jump;
    logic            w_eq, w_ult, w_slt, w_cmp;
    logic            w_illegal, w_taken, w_misalign, w_redirect;
    logic [XLEN-1:0] w_link, w_jump_tgt, w_target;

    assign w_lt   = r_funct3[2];
    assign w_uns  = r_funct3[1];
    assign w_inv  = r_funct3[0];
    assign w_jump = r_jal | r_jalr;

    assign w_eq  = (r_rs1 == r_rs2);
    assign w_ult = (r_rs1 < r_rs2);
    assign w_slt = ({~r_rs1[XLEN-1], r_rs1[XLEN-2:0]} < {~r_rs2[XLEN-1], r_rs2[XLEN-2:0]});
    assign w_cmp = w_lt ? (w_uns ? w_ult : w_slt) : w_eq;

    assign w_illegal  = !w_jump && !w_lt && w_uns;
    assign w_taken    = w_jump | (!w_illegal & (w_cmp ^ w_inv));
    assign w_link     = r_pc + XLEN'(4);
    assign w_jump_tgt = r_jalr ? ((r_rs1 + r_imm) & ~XLEN'(1)) : (r_pc + r_imm);
    assign w_target   = w_taken ? w_jump_tgt : w_link;
    assign w_misalign = w_taken & (w_target[1:0] != 2'b00);
    assign w_redirect = w_taken & !w_misalign & !w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_taken    <= 1'b0;
            res_redirect <= 1'b0;
            res_target   <= '0;
            res_link     <= '0;
            res_misalign <= 1'b0;
            res_illegal  <= 1'b0;
        end else if (flush || (r_state == S_HOLD && res_ready)) begin
            res_taken    <= 1'b0;
            res_redirect <= 1'b0;
            res_target   <= '0;
            res_link     <= '0;
            res_misalign <= 1'b0;
            res_illegal  <= 1'b0;
        end else if (r_state == S_EVAL) begin
            res_taken    <= w_taken;
            res_redirect <= w_redirect;
            res_target   <= w_target;
            res_link     <= w_link;
            res_misalign <= w_misalign;
            res_illegal  <= w_illegal;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed results, latency, backpressure, flush and reset.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_imm, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_jal, in_jalr;
    logic        res_valid, res_ready;
    logic        res_taken, res_redirect, res_misalign, res_illegal;
    logic [31:0] res_target, res_link;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    branch_resolve #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_jal(in_jal), .in_jalr(in_jalr),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_taken(res_taken), .res_redirect(res_redirect),
        .res_target(res_target), .res_link(res_link),
        .res_misalign(res_misalign), .res_illegal(res_illegal),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one instruction at a negedge; returns at the next negedge with in_valid low.
    task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [2:0] f3, input logic jal,
                         input logic jalr);
        @(negedge clk);
        in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_jal = jal; in_jalr = jalr;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called one negedge after acceptance: checks EVAL, then the held result, then consumes it.
    task automatic expect_res(input string tag, input logic taken, input logic redirect,
                              input logic [31:0] target, input logic [31:0] link,
                              input logic mis, input logic ill);
        chk({tag, "_eval_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_eval_state"}, 32'(dbg_state), 32'd1);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_taken"}, 32'(res_taken), 32'(taken));
        chk({tag, "_redirect"}, 32'(res_redirect), 32'(redirect));
        chk({tag, "_target"}, res_target, target);
        chk({tag, "_link"}, res_link, link);
        chk({tag, "_misalign"}, 32'(res_misalign), 32'(mis));
        chk({tag, "_illegal"}, 32'(res_illegal), 32'(ill));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_done_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_done_valid"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_jal = 1'b0; in_jalr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_taken", 32'(res_taken), 32'd0);
        chk("rst_target", res_target, 32'd0);
        chk("rst_link", res_link, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        issue(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0, 1'b0);
        expect_res("beq", 1'b1, 1'b1, 32'h120, 32'h104, 1'b0, 1'b0);
        issue(32'h100, 32'h20, 32'd5, 32'd5, 3'b001, 1'b0, 1'b0);
        expect_res("bne", 1'b0, 1'b0, 32'h104, 32'h104, 1'b0, 1'b0);
        issue(32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 1'b0);
        expect_res("blt", 1'b1, 1'b1, 32'h240, 32'h204, 1'b0, 1'b0);
        issue(32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 1'b0);
        expect_res("bltu", 1'b0, 1'b0, 32'h204, 32'h204, 1'b0, 1'b0);
        issue(32'h300, 32'hFFFF_FFF0, 32'd1, 32'hFFFF_FFFF, 3'b101, 1'b0, 1'b0);
        expect_res("bge", 1'b1, 1'b1, 32'h2F0, 32'h304, 1'b0, 1'b0);
        issue(32'h300, 32'hFFFF_FFF0, 32'd1, 32'hFFFF_FFFF, 3'b111, 1'b0, 1'b0);
        expect_res("bgeu", 1'b0, 1'b0, 32'h304, 32'h304, 1'b0, 1'b0);
        issue(32'h400, 32'h0, 32'h203, 32'h0, 3'b000, 1'b0, 1'b1);
        expect_res("jalr_mis", 1'b1, 1'b0, 32'h202, 32'h404, 1'b1, 1'b0);
        issue(32'hFFFF_FFF0, 32'h20, 32'h0, 32'h1, 3'b010, 1'b1, 1'b0);
        expect_res("jal_wrap", 1'b1, 1'b1, 32'h10, 32'hFFFF_FFF4, 1'b0, 1'b0);
        issue(32'h500, 32'h20, 32'd3, 32'd3, 3'b010, 1'b0, 1'b0);
        expect_res("illegal", 1'b0, 1'b0, 32'h504, 32'h504, 1'b0, 1'b1);
        issue(32'h600, 32'h8, 32'h1001, 32'h0, 3'b000, 1'b1, 1'b1);
        expect_res("jal_jalr", 1'b1, 1'b1, 32'h1008, 32'h604, 1'b0, 1'b0);
        issue(32'h700, 32'h6, 32'd9, 32'd9, 3'b000, 1'b0, 1'b0);
        expect_res("br_mis", 1'b1, 1'b0, 32'h706, 32'h704, 1'b1, 1'b0);

        // Backpressure: result held for 5 cycles while a new branch waits on in_valid.
        issue(32'h800, 32'h10, 32'd7, 32'd7, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        in_pc = 32'h900; in_imm = 32'h8; in_rs1 = 32'd1; in_rs2 = 32'd2;
        in_funct3 = 3'b001; in_jal = 1'b0; in_jalr = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid_%0d", i), 32'(res_valid), 32'd1);
            chk($sformatf("bp_target_%0d", i), res_target, 32'h810);
            chk($sformatf("bp_link_%0d", i), res_link, 32'h804);
            chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_after_state", 32'(dbg_state), 32'd0);
        chk("bp_after_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        expect_res("bp_next", 1'b1, 1'b1, 32'h908, 32'h904, 1'b0, 1'b0);

        // Flush in EVAL: result never appears.
        issue(32'hA00, 32'h40, 32'd1, 32'd1, 3'b000, 1'b0, 1'b0);
        chk("fl_eval_state", 32'(dbg_state), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_eval_idle", 32'(dbg_state), 32'd0);
        chk("fl_eval_valid0", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("fl_eval_valid1", 32'(res_valid), 32'd0);
        chk("fl_eval_target", res_target, 32'd0);

        // Flush coinciding with an input handshake drops the instruction.
        @(negedge clk);
        in_pc = 32'hB00; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_in_state", 32'(dbg_state), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);

        // Flush in HOLD with res_ready high: flush wins, outputs clear.
        issue(32'hC00, 32'h40, 32'd1, 32'd2, 3'b001, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_hold_valid", 32'(res_valid), 32'd1);
        flush = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; res_ready = 1'b0;
        chk("fl_hold_valid0", 32'(res_valid), 32'd0);
        chk("fl_hold_taken", 32'(res_taken), 32'd0);
        chk("fl_hold_target", res_target, 32'd0);
        chk("fl_hold_state", 32'(dbg_state), 32'd0);
        issue(32'hD00, 32'h10, 32'd4, 32'd3, 3'b101, 1'b0, 1'b0);
        expect_res("post_flush", 1'b1, 1'b1, 32'hD10, 32'hD04, 1'b0, 1'b0);

        // Reset pulse in HOLD clears immediately.
        issue(32'hE00, 32'h20, 32'd2, 32'd2, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        chk("rp_hold_valid", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rp_valid", 32'(res_valid), 32'd0);
        chk("rp_target", res_target, 32'd0);
        chk("rp_link", res_link, 32'd0);
        chk("rp_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'hF00, 32'h80, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1'b0, 1'b0);
        expect_res("post_rst", 1'b1, 1'b1, 32'hF80, 32'hF04, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
